// File: rtl/pcie_dllp_crc_gen.sv
// DLLP CRC generator: folds a 4-byte DLLP body through the 16-bit DLLP CRC one byte per clock,
// then holds body plus inverted CRC for the downstream handshake; 4 cycles accept->valid, stalls input while output is held.
module pcie_dllp_crc_gen #(
  parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_dllp_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [47:0] out_dllp_o,
  output logic [15:0] dllp_count_o
);

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_e;

  state_e      state_q;
  logic [31:0] body_q;
  logic [15:0] crc_q;
  logic [15:0] crc_d;
  logic [1:0]  byte_idx_q;
  logic [47:0] out_dllp_q;
  logic [15:0] dllp_count_q;
  logic [7:0]  cur_byte;

  function automatic logic [15:0] crc_byte(input logic [15:0] c_in, input logic [7:0] b);
    logic [15:0] c;
    c = c_in ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hD008) : (c >> 1);
    end
    return c;
  endfunction

  always_comb begin
    cur_byte = body_q[7:0];
    unique case (byte_idx_q)
      2'd0: cur_byte = body_q[7:0];
      2'd1: cur_byte = body_q[15:8];
      2'd2: cur_byte = body_q[23:16];
      2'd3: cur_byte = body_q[31:24];
      default: cur_byte = body_q[7:0];
    endcase
  end

  assign crc_d = crc_byte(crc_q, cur_byte);

  // Ready in OUT follows out_ready_i so a new body can enter on the delivery cycle.
  assign in_ready_o   = (state_q == IDLE) || ((state_q == OUT) && out_ready_i);
  assign out_valid_o  = (state_q == OUT);
  assign out_dllp_o   = out_dllp_q;
  assign dllp_count_o = dllp_count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      body_q       <= 32'h0;
      crc_q        <= CRC_INIT;
      byte_idx_q   <= 2'd0;
      out_dllp_q   <= 48'h0;
      dllp_count_q <= 16'h0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            body_q     <= in_dllp_i;
            crc_q      <= CRC_INIT;
            byte_idx_q <= 2'd0;
            state_q    <= CALC;
          end
        end
        CALC: begin
          crc_q      <= crc_d;
          byte_idx_q <= byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            out_dllp_q <= {~crc_d, body_q};
            state_q    <= OUT;
          end
        end
        OUT: begin
          if (out_ready_i) begin
            dllp_count_q <= dllp_count_q + 16'd1;
            if (in_valid_i) begin
              body_q     <= in_dllp_i;
              crc_q      <= CRC_INIT;
              byte_idx_q <= 2'd0;
              state_q    <= CALC;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pcie_dllp_crc_gen.md
# pcie_dllp_crc_gen

Transmit-side DLLP CRC generator for the data link layer. It accepts a 4-byte DLLP body (type plus payload) over a valid/ready handshake and runs the 16-bit DLLP CRC over it one byte per clock. It then presents the completed 6-byte DLLP (body plus inverted CRC) to the downstream framer/TX mux over a second valid/ready handshake. It sits between the DLLP scheduler (ACK/NAK, UpdateFC, PM DLLPs) and the physical-layer framing stage.

## Interface
- `CRC_INIT`, default 16'hFFFF: CRC register seed loaded at each accepted DLLP.
- `clk_i`  in  1: single clock; all state changes on its rising edge.
- `rst_i`  in  1: reset, synchronous, active-high.
- `in_valid_i`  in  1: DLLP body valid.
- `in_ready_o`  out  1: block can accept a body this cycle.
- `in_dllp_i`  in  32: DLLP body; byte0 (DLLP type) = [7:0], byte1 = [15:8], byte2 = [23:16], byte3 = [31:24].
- `out_valid_o`  out  1: completed DLLP valid.
- `out_ready_i`  in  1: downstream accepts the DLLP.
- `out_dllp_o`  out  48: [31:0] = body unchanged; [39:32] = CRC byte4; [47:40] = CRC byte5.
- `dllp_count_o`  out  16: count of DLLPs delivered (output handshakes); wraps 16'hFFFF -> 16'h0000.

## Operation
- States:
  - IDLE: waiting for a body.
  - CALC: folding bytes, counter `byte_idx` runs 0..3.
  - OUT: holding the result until the output handshake.
- CRC byte step, applied to register c and byte b:
  - c = c ^ {8'h00, b}.
  - Then 8 iterations: if c[0], c = (c >> 1) ^ 16'hD008; else c = c >> 1.
- IDLE:
  - `in_ready_o` = 1.
  - On in_valid & in_ready: latch the body, set c = CRC_INIT, byte_idx = 0, go to CALC.
- CALC:
  - Each cycle apply the byte step to c with byte[byte_idx], then increment byte_idx.
  - After the step with byte_idx = 3, go to OUT and register the result: final = ~c, byte4 = final[7:0], byte5 = final[15:8].
- OUT:
  - `out_valid_o` = 1 and `out_dllp_o` is stable until the output handshake completes.
  - On out_valid & out_ready: increment `dllp_count_o`.
  - If in_valid_i is also high in that same cycle, accept the new body directly and go to CALC (in_ready_o = out_ready_i while in OUT). Otherwise go to IDLE.
- `in_ready_o` is 0 in CALC and in OUT when out_ready_i = 0. The combinational path out_ready_i -> in_ready_o exists only in OUT.
- The latched body is not altered while in CALC or OUT. Changes on `in_dllp_i` while not ready are ignored.

## Timing
- Reset values: state = IDLE, `in_ready_o` = 1, `out_valid_o` = 0, `out_dllp_o` = 48'h0, `dllp_count_o` = 0, c = CRC_INIT, byte_idx = 0.
- Latency:
  - Input accepted at edge E0.
  - Bytes 0..3 folded at edges E1..E4.
  - `out_valid_o` high in the cycle after E4, i.e. 4 cycles after acceptance.
- Throughput: one DLLP per 5 cycles sustained, when out_ready_i is held at 1 and in_valid_i is held at 1.
- Backpressure: `out_valid_o` stays asserted and `out_dllp_o` is unchanged for any number of cycles with out_ready_i = 0. No input is accepted during that time.
- `rst_i` asserted in any state, including mid-CALC or in OUT with valid asserted: at the next edge all outputs return to reset values and any partial DLLP is discarded.
  - A body presented in the same cycle as reset is not accepted.
  - A pending output is not counted.
- `dllp_count_o` wraps without a flag.

## Test plan
- Reset, then a single body 32'h0000_0000 with out_ready held at 1 -> in_ready drops for 4 cycles, `out_valid_o` high exactly 4 cycles after acceptance, [31:0] = 0, CRC bytes equal the bit-serial model with CRC_INIT = 16'hFFFF, `dllp_count_o` = 1.
- Ack DLLP body 32'h0000_0A00 and UpdateFC-P body 32'h0100_4040 -> bytes [47:32] match the model; byte order of CRC = {final[15:8], final[7:0]}.
- out_ready held at 0 for 10 cycles after valid -> `out_dllp_o` stable, in_ready = 0, count unchanged; on release, one handshake and count increments by exactly 1.
- in_valid held high with 3 random bodies, out_ready = 1 -> outputs in order, 5-cycle spacing, each accepted in the same cycle its predecessor is delivered.
- `rst_i` pulsed during CALC at byte_idx = 2, then during OUT with valid high -> at the next edge `out_valid_o` = 0, in_ready = 1, count = 0; the next body produces a correct CRC.
- Preload the count via 65535 handshakes (or force) -> next delivery wraps `dllp_count_o` to 16'h0000.
